// File: rtl/lsmitll_dro_sampled.sv
// Sampled model of an SFQ destructive readout cell: toggle-coded data/clock in, toggle-coded q out.
// Optional LSMITLL_DRO_VIOL_CNT_EN adds a saturating 8-bit violation counter port.
module lsmitll_dro_sampled #(
  parameter int DELAY  = 3,
  parameter int CT_CYC = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             clk_sfq,
  output logic             q,
  output logic             err,
  output logic [CNT_W-1:0] out_cnt
`ifdef LSMITLL_DRO_VIOL_CNT_EN
  ,
  output logic [7:0]       viol_cnt
`endif
);

  typedef enum logic {EMPTY, STORED} state_t;

  localparam logic [2:0] CT_LD = 3'(CT_CYC);

  state_t           state, state_nxt;
  logic             a_d, c_d;
  logic             dp, cp, in_win, viol, sched;
  logic [2:0]       win_p0;
  logic [DELAY-1:0] vld_p;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
    if (inc && (v != 8'hFF)) return v + 8'd1;
    return v;
  endfunction

  assign dp     = a ^ a_d;
  assign cp     = clk_sfq ^ c_d;
  assign in_win = (win_p0 != 3'd0);

  // A clock pulse always wins over a coincident data pulse; data inside the window is dropped.
  always_comb begin
    state_nxt = state;
    sched     = 1'b0;
    viol      = 1'b0;
    if (cp) begin
      viol      = dp;
      sched     = (state == STORED);
      state_nxt = EMPTY;
    end else if (dp) begin
      if (in_win) begin
        viol      = 1'b1;
        state_nxt = EMPTY;
      end else begin
        state_nxt = STORED;
      end
    end
  end

  // Edge-detect history loads every cycle, so levels held through reset never look like pulses.
  always_ff @(posedge clk) begin
    a_d <= a;
    c_d <= clk_sfq;
  end

  // Stage p0: window counter and output pipeline; q toggles when a pulse leaves the last stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      win_p0  <= 3'd0;
      vld_p   <= '0;
      q       <= 1'b0;
      err     <= 1'b0;
      out_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (cp)          win_p0 <= CT_LD;
      else if (in_win) win_p0 <= win_p0 - 3'd1;
      vld_p <= (vld_p << 1) | DELAY'(sched);
      if (vld_p[DELAY-1]) begin
        q       <= ~q;
        out_cnt <= out_cnt + CNT_W'(1);
      end
      if (viol) err <= 1'b1;
    end
  end

`ifdef LSMITLL_DRO_VIOL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) viol_cnt <= 8'd0;
    else     viol_cnt <= sat_inc8(viol_cnt, viol);
  end
`endif

endmodule

// File: tb/tb_lsmitll_dro_sampled.sv
// Bench for lsmitll_dro_sampled: two configurations driven in lockstep against a timestamp-based model.
module tb_lsmitll_dro_sampled;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a = 1'b0;
  logic        clk_sfq = 1'b0;
  logic        q0, err0, q1, err1;
  logic [15:0] cnt0, cnt1;
`ifdef LSMITLL_DRO_VIOL_CNT_EN
  logic [7:0]  vc0, vc1;
`endif

  always #5 clk = ~clk;

  lsmitll_dro_sampled #(.DELAY(3), .CT_CYC(2), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .a(a), .clk_sfq(clk_sfq),
    .q(q0), .err(err0), .out_cnt(cnt0)
`ifdef LSMITLL_DRO_VIOL_CNT_EN
    , .viol_cnt(vc0)
`endif
  );

  lsmitll_dro_sampled #(.DELAY(4), .CT_CYC(0), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .a(a), .clk_sfq(clk_sfq),
    .q(q1), .err(err1), .out_cnt(cnt1)
`ifdef LSMITLL_DRO_VIOL_CNT_EN
    , .viol_cnt(vc1)
`endif
  );

  int total = 0;
  int bad   = 0;
  int n     = 0;

  int        dly [2] = '{3, 4};
  int        ctw [2] = '{2, 0};
  logic      m_ad [2], m_cd [2], m_st [2], m_q [2], m_err [2];
  int        m_cnt [2], m_last [2];
  bit [31:0] pend [2];

  typedef struct {
    logic r, av, cv, eq, ee;
    int   ecnt;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0d want %0d", name, n, act, exp);
    end
  endtask

  // Model: outputs are timestamps (clock edge + delay); the window is a distance to the last clock pulse.
  function automatic void model(input int k, input logic r, input logic av, input logic cv);
    logic dp, cp, in_win, viol;
    if (r) begin
      m_st[k] = 1'b0; m_q[k] = 1'b0; m_err[k] = 1'b0; m_cnt[k] = 0;
      m_last[k] = -1000; pend[k] = '0;
    end else begin
      dp = (av != m_ad[k]);
      cp = (cv != m_cd[k]);
      if (pend[k][n % 32]) begin
        m_q[k] = ~m_q[k];
        m_cnt[k]++;
        pend[k][n % 32] = 1'b0;
      end
      in_win = ((n - m_last[k]) >= 1) && ((n - m_last[k]) <= ctw[k]);
      viol = dp && (cp || in_win);
      if (cp) begin
        if (m_st[k]) pend[k][(n + dly[k]) % 32] = 1'b1;
        m_st[k]   = 1'b0;
        m_last[k] = n;
      end else if (dp) begin
        m_st[k] = !viol;
      end
      if (viol) m_err[k] = 1'b1;
    end
    m_ad[k] = av;
    m_cd[k] = cv;
  endfunction

  task automatic step(input logic r, input logic av, input logic cv);
    rst = r; a = av; clk_sfq = cv;
    @(posedge clk);
    n++;
    model(0, r, av, cv);
    model(1, r, av, cv);
    #1;
    check("mdl_q0", int'(q0), int'(m_q[0]));
    check("mdl_err0", int'(err0), int'(m_err[0]));
    check("mdl_cnt0", int'(cnt0), m_cnt[0] % 65536);
    check("mdl_q1", int'(q1), int'(m_q[1]));
    check("mdl_err1", int'(err1), int'(m_err[1]));
    check("mdl_cnt1", int'(cnt1), m_cnt[1] % 65536);
  endtask

  task automatic run_to(input int e, input logic av, input logic cv);
    while (n < e) step(1'b0, av, cv);
  endtask

  task automatic seq_reset(input logic av, input logic cv);
    n = 0;
    step(1'b1, av, cv);
    step(1'b1, av, cv);
  endtask

  function automatic void add(input logic r, input logic av, input logic cv,
                              input logic eq, input logic ee, input int ecnt);
    vec_t v;
    v.r = r; v.av = av; v.cv = cv; v.eq = eq; v.ee = ee; v.ecnt = ecnt;
    tbl.push_back(v);
  endfunction

  initial begin
    logic ra, rc, rr;
    // Data rises at edge 5, clock at 10 -> q at 13; clock at 17 finds EMPTY -> nothing.
    add(1, 0, 0, 0, 0, 0); add(1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0);
    for (int e = 5; e <= 9; e++)   add(0, 1, 0, 0, 0, 0);
    for (int e = 10; e <= 12; e++) add(0, 1, 1, 0, 0, 0);
    for (int e = 13; e <= 16; e++) add(0, 1, 1, 1, 0, 1);
    for (int e = 17; e <= 24; e++) add(0, 1, 0, 1, 0, 1);
    n = 0;
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].av, tbl[i].cv);
      check("tbl_q", int'(q0), int'(tbl[i].eq));
      check("tbl_err", int'(err0), int'(tbl[i].ee));
      check("tbl_cnt", int'(cnt0), tbl[i].ecnt);
    end

    // Data inside the window after a clock pulse
    seq_reset(0, 0);
    run_to(4, 0, 0); run_to(9, 1, 0); run_to(11, 1, 1);
    check("win_err_before", int'(err0), 0);
    run_to(12, 0, 1);
    check("win_err0", int'(err0), 1);
    check("win_ct0_err1", int'(err1), 0);
    run_to(13, 0, 1);
    check("win_q0", int'(q0), 1);
    check("win_cnt0", int'(cnt0), 1);
    run_to(19, 0, 1); run_to(25, 0, 0);
    check("win_cnt0_after", int'(cnt0), 1);
    check("win_ct0_cnt1", int'(cnt1), 2);

    // Coincident data and clock pulses
    seq_reset(0, 0);
    run_to(3, 0, 0); run_to(9, 1, 0); run_to(10, 0, 1);
    check("coin_err0", int'(err0), 1);
    check("coin_err1", int'(err1), 1);
    run_to(12, 0, 1);
    check("coin_q0_early", int'(q0), 0);
    run_to(13, 0, 1);
    check("coin_q0", int'(q0), 1);
    run_to(14, 0, 1);
    check("coin_cnt1", int'(cnt1), 1);
    run_to(20, 0, 0);
    check("coin_cnt0_end", int'(cnt0), 1);
    check("coin_cnt1_end", int'(cnt1), 1);

    // Two pulses in flight at once in the DELAY=4 pipeline
    seq_reset(0, 0);
    run_to(4, 0, 0); run_to(5, 1, 0); run_to(6, 1, 1); run_to(7, 0, 1); run_to(9, 0, 0);
    check("pipe_cnt1_pre", int'(cnt1), 0);
    run_to(10, 0, 0);
    check("pipe_q1_a", int'(q1), 1);
    run_to(12, 0, 0);
    check("pipe_q1_b", int'(q1), 0);
    check("pipe_cnt1", int'(cnt1), 2);
    check("pipe_err0", int'(err0), 1);
    check("pipe_cnt0", int'(cnt0), 1);

    // High levels held through reset release
    seq_reset(1, 1);
    run_to(20, 1, 1);
    check("rel_q0", int'(q0), 0);
    check("rel_cnt0", int'(cnt0), 0);
    check("rel_err0", int'(err0), 0);
    check("rel_cnt1", int'(cnt1), 0);

    // Random traffic with occasional mid-run reset
    seq_reset(0, 0);
    ra = 1'b0; rc = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) ra = ~ra;
      if ($urandom_range(0, 3) == 0) rc = ~rc;
      rr = ($urandom_range(0, 199) == 0);
      step(rr, ra, rc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsmitll_dro_sampled.md
LSMITLL_DRO_SAMPLED -- requirements
Module: lsmitll_dro_sampled

Interface
REQ-001 Parameter DELAY, default 3: clock cycles from detected SFQ clock pulse to output pulse; legal range 1..15.
REQ-002 Parameter CT_CYC, default 2: data critical window in cycles after an SFQ clock pulse; legal range 0..7.
REQ-003 Parameter CNT_W, default 16: width of out_cnt.
REQ-004 Port clk  input  1: single system sampling clock; all logic on its rising edge.
REQ-005 Port rst  input  1: reset, synchronous and active-high.
REQ-006 Port a  input  1: toggle-encoded SFQ data; every transition of a is one pulse; driven by the upstream NOTT stage output.
REQ-007 Port clk_sfq  input  1: toggle-encoded SFQ clock; every transition is one clock pulse.
REQ-008 Port q  output  1: toggle-encoded SFQ output, registered.
REQ-009 Port err  output  1: sticky timing-violation flag, registered.
REQ-010 Port out_cnt  output  CNT_W: count of output pulses emitted; wraps modulo 2^CNT_W.

Function
REQ-011 A data pulse SHALL be detected at edge n when a differs from a_d, the registered value of a at edge n-1; the clock pulse (clk_sfq vs c_d) SHALL be detected the same way.
REQ-012 The storage FSM SHALL have two states: EMPTY and STORED.
REQ-013 Valid data pulse in EMPTY -> STORED; valid data pulse in STORED -> remain STORED, no other effect.
REQ-014 Clock pulse in STORED -> EMPTY and schedule one output pulse; clock pulse in EMPTY -> remain EMPTY, no output.
REQ-015 A scheduled output pulse SHALL toggle q exactly DELAY edges after the detecting edge, using a DELAY-deep shift pipeline; out_cnt increments on the same edge.
REQ-016 Successive clock pulses on consecutive edges SHALL each be handled independently; the pipeline never merges or drops scheduled pulses.
REQ-017 A data pulse detected at edges n+1..n+CT_CYC after a clock pulse at edge n SHALL be a violation; the window restarts on every clock pulse.
REQ-018 A data pulse and a clock pulse detected on the same edge SHALL be a violation: the clock pulse is processed per REQ-014 and the data pulse is discarded.
REQ-019 On a violation the data pulse SHALL be discarded, the state SHALL be forced to EMPTY (except as given in REQ-018), and err SHALL be set to 1 until reset; pending pipeline pulses are unaffected.
REQ-020 CT_CYC=0 SHALL disable REQ-017; REQ-018 still applies.

Reset
REQ-021 While rst=1 at an edge: q=0, err=0, out_cnt=0, state=EMPTY, pipeline cleared, window counter cleared.
REQ-022 While rst=1, a_d SHALL load a and c_d SHALL load clk_sfq, so that non-zero input levels at reset release produce no pulse.
REQ-023 Reset asserted mid-operation SHALL discard stored data and all in-flight output pulses; the first detection is possible at the edge after rst deasserts.

Configuration
REQ-024 Macro LSMITLL_DRO_VIOL_CNT_EN defined: add output port viol_cnt  output  8, counting violations, saturating at 255, cleared by reset.
REQ-025 Macro LSMITLL_DRO_VIOL_CNT_EN undefined: port viol_cnt absent; all other behaviour identical.

Verification
REQ-026 Reset, a 0->1 at edge 5, clk_sfq 0->1 at edge 10, DELAY=3 -> q toggles 0->1 at edge 13, out_cnt=1, err=0.
REQ-027 Clock pulse at edge 10 with state EMPTY -> q unchanged through edge 20, out_cnt=0.
REQ-028 CT_CYC=2, clock pulse at edge 10, data pulse at edge 12 -> err=1 from edge 12, state EMPTY; next clock pulse at edge 20 -> no output.
REQ-029 Data pulse and clock pulse both at edge 10 with STORED held since edge 4 -> output at edge 13, err=1, state EMPTY after edge 10.
REQ-030 Clock pulses at edges 10 and 11, each preceded by a valid data pulse -> q toggles at edges 13 and 14, out_cnt=2.
REQ-031 a=1 and clk_sfq=1 during reset, rst deasserted at edge 3, inputs held -> no pulses detected; q=0 and out_cnt=0 through edge 20.
